// File: rtl/bayer_frame_server.sv
// ============================================================================
//  Module   : bayer_frame_server
//  Purpose  : Frame store for the demosaic engine. It serves Bayer pixel reads,
//             captures the result pixels the engine writes back and reports when
//             the frame is complete.
//  Options  : define BAYER_STALL_EN to add LFSR-driven read stalls on bayer_ready.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bayer_frame_server #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 14,
   parameter int IMG_W      = 128,
   parameter int IMG_H      = 128
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_valid,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  start,
   output logic                  bayer_ready,
   input  logic                  bayer_req,
   input  logic [ADDR_WIDTH-1:0] bayer_addr,
   output logic [DATA_WIDTH-1:0] bayer_data,
   input  logic                  acpi_valid,
   input  logic [ADDR_WIDTH-1:0] acpi_addr,
   input  logic [DATA_WIDTH-1:0] acpi_data,
   input  logic                  finish,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [ADDR_WIDTH:0]   wr_count,
   output logic                  busy,
   output logic                  done,
   output logic                  addr_err
);

   localparam int                  c_DEPTH    = 2**ADDR_WIDTH;
   localparam int                  c_COL_BITS = $clog2(IMG_W);
   localparam logic [ADDR_WIDTH-1:0] c_COL_LAST = ADDR_WIDTH'(IMG_W - 1);
   localparam logic [ADDR_WIDTH:0] c_ROWS     = (ADDR_WIDTH+1)'(IMG_H);
   localparam logic [ADDR_WIDTH:0] c_FRAME_WR = (ADDR_WIDTH+1)'((IMG_W - 2) * IMG_H);
   localparam logic [ADDR_WIDTH:0] c_WR_MAX   = (ADDR_WIDTH+1)'(c_DEPTH);
   localparam logic [ADDR_WIDTH:0] c_WR_ONE   = (ADDR_WIDTH+1)'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SERVE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                r_state;
   logic [1:0]            r_drain_cnt;
   logic                  r_ready;
   logic [DATA_WIDTH-1:0] r_bayer_data;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic [ADDR_WIDTH:0]   r_wr_count;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_addr_err;

   logic [DATA_WIDTH-1:0] r_in_mem  [c_DEPTH];
   logic [DATA_WIDTH-1:0] r_out_mem [c_DEPTH];

   logic [ADDR_WIDTH-1:0] w_col;
   logic [ADDR_WIDTH-1:0] w_row;
   logic                  w_bad_addr;
   logic                  w_wr_en;
   logic                  w_ld_en;
   logic                  w_start_ok;
   logic [ADDR_WIDTH:0]   w_cnt_inc;
   logic                  w_serve_ok;

   assign w_col      = acpi_addr & c_COL_LAST;
   assign w_row      = acpi_addr >> c_COL_BITS;
   assign w_bad_addr = (w_col == '0) || (w_col == c_COL_LAST) || ({1'b0, w_row} >= c_ROWS);
   assign w_wr_en    = acpi_valid && (r_state != ST_IDLE) && !rst;
   assign w_start_ok = (r_state == ST_IDLE) || (r_state == ST_DONE);
   assign w_ld_en    = load_valid && w_start_ok && !rst;
   assign w_cnt_inc  = (r_wr_count == c_WR_MAX) ? r_wr_count : r_wr_count + c_WR_ONE;

`ifdef BAYER_STALL_EN
   // Fibonacci LFSR x^16+x^14+x^13+x^11+1; a cycle stalls when the new low bits are 00.
   logic [15:0] r_lfsr;
   logic [15:0] w_lfsr_next;
   logic [31:0] r_stall_cnt;
   logic [31:0] r_rd_cnt;

   assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
   assign w_serve_ok  = (w_lfsr_next[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfsr      <= 16'hACE1;
         r_stall_cnt <= '0;
         r_rd_cnt    <= '0;
      end else if (start && w_start_ok) begin
         r_lfsr      <= 16'hACE1;
      end else if (r_state == ST_SERVE) begin
         r_lfsr <= w_lfsr_next;
         if (!w_serve_ok)
            r_stall_cnt <= r_stall_cnt + 32'd1;
         if (bayer_req && r_ready)
            r_rd_cnt <= r_rd_cnt + 32'd1;
      end
   end
`else
   logic w_unused_req;
   assign w_unused_req = bayer_req;
   assign w_serve_ok   = 1'b1;
`endif

   // Frame memories carry no reset so they map onto block RAM.
   always_ff @(posedge clk) begin
      if (w_ld_en)
         r_in_mem[load_addr] <= load_data;
      if (w_wr_en)
         r_out_mem[acpi_addr] <= acpi_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_drain_cnt  <= 2'd0;
         r_ready      <= 1'b0;
         r_bayer_data <= '0;
         r_rd_data    <= '0;
         r_wr_count   <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_addr_err   <= 1'b0;
      end else begin
         r_rd_data <= r_out_mem[rd_addr];
         if (w_wr_en) begin
            r_wr_count <= w_cnt_inc;
            if (w_bad_addr)
               r_addr_err <= 1'b1;
         end
         case (r_state)
            ST_IDLE, ST_DONE: begin
               r_ready <= 1'b0;
               if (start) begin
                  r_state    <= ST_SERVE;
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
                  r_wr_count <= '0;
                  r_addr_err <= 1'b0;
               end
            end
            ST_SERVE: begin
               if (w_serve_ok)
                  r_bayer_data <= r_in_mem[bayer_addr];
               if (finish || (w_wr_en && (w_cnt_inc == c_FRAME_WR))) begin
                  r_state     <= ST_DRAIN;
                  r_ready     <= 1'b0;
                  r_drain_cnt <= 2'd0;
               end else begin
                  r_ready <= w_serve_ok;
               end
            end
            ST_DRAIN: begin
               r_ready <= 1'b0;
               if (r_drain_cnt == 2'd3) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_drain_cnt <= r_drain_cnt + 2'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bayer_ready = r_ready;
   assign bayer_data  = r_bayer_data;
   assign rd_data     = r_rd_data;
   assign wr_count    = r_wr_count;
   assign busy        = r_busy;
   assign done        = r_done;
   assign addr_err    = r_addr_err;

endmodule

`default_nettype wire

// File: tb/tb_bayer_frame_server.sv
// ============================================================================
//  Module   : tb_bayer_frame_server
//  Purpose  : Directed self-checking bench for bayer_frame_server.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bayer_frame_server;

   localparam int AW = 14;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_valid;
   logic [AW-1:0] load_addr;
   logic [DW-1:0] load_data;
   logic          start;
   logic          bayer_ready;
   logic          bayer_req;
   logic [AW-1:0] bayer_addr;
   logic [DW-1:0] bayer_data;
   logic          acpi_valid;
   logic [AW-1:0] acpi_addr;
   logic [DW-1:0] acpi_data;
   logic          finish;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic [AW:0]   wr_count;
   logic          busy;
   logic          done;
   logic          addr_err;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bayer_frame_server #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMG_W(128), .IMG_H(128)) dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
      .start(start), .bayer_ready(bayer_ready), .bayer_req(bayer_req),
      .bayer_addr(bayer_addr), .bayer_data(bayer_data),
      .acpi_valid(acpi_valid), .acpi_addr(acpi_addr), .acpi_data(acpi_data),
      .finish(finish), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_count(wr_count), .busy(busy), .done(done), .addr_err(addr_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic eng_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      acpi_valid = 1'b1;
      acpi_addr  = a;
      acpi_data  = d;
      tick();
      acpi_valid = 1'b0;
   endtask

   task automatic host_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
      load_valid = 1'b1;
      load_addr  = a;
      load_data  = d;
      tick();
      load_valid = 1'b0;
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   initial begin
      logic [AW-1:0] a;
      rst = 1'b1; load_valid = 1'b0; load_addr = '0; load_data = '0; start = 1'b0;
      bayer_req = 1'b0; bayer_addr = '0; acpi_valid = 1'b0; acpi_addr = '0;
      acpi_data = '0; finish = 1'b0; rd_addr = '0;
      tick(2);
      rst = 1'b0;
      check("rst_ready",  32'(bayer_ready), 32'd0);
      check("rst_busy",   32'(busy),        32'd0);
      check("rst_done",   32'(done),        32'd0);
      check("rst_wrcnt",  32'(wr_count),    32'd0);
      check("rst_err",    32'(addr_err),    32'd0);
      check("rst_bdata",  32'(bayer_data),  32'd0);

      finish = 1'b1; tick(); finish = 1'b0;
      check("idle_finish_busy", 32'(busy), 32'd0);
      check("idle_finish_done", 32'(done), 32'd0);

      host_load(14'd129, 8'h5A);
      host_load(14'd385, 8'h3C);

      bayer_req = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      check("start_busy",  32'(busy),        32'd1);
      check("start_ready", 32'(bayer_ready), 32'd0);
`ifndef BAYER_STALL_EN
      bayer_addr = 14'd129; tick();
      check("ready_up",  32'(bayer_ready), 32'd1);
      check("rd_129",    32'(bayer_data),  32'h5A);
      bayer_addr = 14'd385; tick();
      check("rd_385",    32'(bayer_data),  32'h3C);
`endif
      host_load(14'd129, 8'hFF);
`ifndef BAYER_STALL_EN
      bayer_addr = 14'd129; tick();
      check("load_in_serve_ignored", 32'(bayer_data), 32'h5A);
`endif

      // Early finish after ten interior writes.
      for (int i = 0; i < 10; i++) eng_wr(14'(257 + i), 8'(i));
      check("early_cnt10", 32'(wr_count), 32'd10);
      finish = 1'b1; tick(); finish = 1'b0;
      check("drain_busy",  32'(busy),        32'd1);
      check("drain_ready", 32'(bayer_ready), 32'd0);
      eng_wr(14'd300, 8'h42);
      check("drain_wr_cnt", 32'(wr_count), 32'd11);
      tick(2);
      check("drain_not_done", 32'(done), 32'd0);
      tick();
      check("early_done", 32'(done),     32'd1);
      check("early_idle", 32'(busy),     32'd0);
      check("early_cnt",  32'(wr_count), 32'd11);
      rd_addr = 14'd300; tick();
      check("rb_300", 32'(rd_data), 32'h42);

      // Border write: stored, counted and flagged.
      start = 1'b1; tick(); start = 1'b0;
      check("restart_done", 32'(done),     32'd0);
      check("restart_cnt",  32'(wr_count), 32'd0);
      eng_wr(14'd128, 8'h77);
      check("border_err", 32'(addr_err), 32'd1);
      check("border_cnt", 32'(wr_count), 32'd1);
      eng_wr(14'd258, 8'h05);
      check("err_sticky", 32'(addr_err), 32'd1);
      finish = 1'b1; tick(); finish = 1'b0;
      tick(4);
      check("border_done", 32'(done), 32'd1);
      rd_addr = 14'd128; tick();
      check("rb_128", 32'(rd_data), 32'h77);
      start = 1'b1; tick(); start = 1'b0;
      check("err_cleared", 32'(addr_err), 32'd0);

      // Full interior frame; DRAIN begins on the write that reaches 16128.
      for (int r = 0; r < 128; r++) begin
         for (int c = 1; c < 127; c++) begin
            a = 14'(r * 128 + c);
            acpi_valid = 1'b1; acpi_addr = a; acpi_data = a[7:0] ^ 8'hA5;
            tick();
         end
      end
      acpi_valid = 1'b0;
      check("frame_cnt",   32'(wr_count),    32'd16128);
      check("frame_drain", 32'(busy),        32'd1);
      check("frame_ready", 32'(bayer_ready), 32'd0);
      tick(3);
      check("frame_not_done", 32'(done), 32'd0);
      tick();
      check("frame_done", 32'(done), 32'd1);
      check("frame_busy", 32'(busy), 32'd0);
      rd_addr = 14'd1; tick();
      check("rb_1", 32'(rd_data), 32'hA4);
      rd_addr = 14'd16254; tick();
      check("rb_last", 32'(rd_data), 32'hDB);

      start = 1'b1; finish = 1'b1; tick(); start = 1'b0; finish = 1'b0;
      check("start_wins_busy", 32'(busy), 32'd1);
      check("start_wins_done", 32'(done), 32'd0);

      rst = 1'b1; acpi_valid = 1'b1; acpi_addr = 14'd2; acpi_data = 8'hEE;
      tick();
      rst = 1'b0; acpi_valid = 1'b0;
      check("midrst_busy",  32'(busy),        32'd0);
      check("midrst_ready", 32'(bayer_ready), 32'd0);
      check("midrst_cnt",   32'(wr_count),    32'd0);
      check("midrst_bdata", 32'(bayer_data),  32'd0);
      rd_addr = 14'd2; tick();
      check("midrst_dropped", 32'(rd_data), 32'hA7);

`ifdef BAYER_STALL_EN
      begin
         logic [15:0]   m;
         logic [DW-1:0] prev;
         int            stalls;
         int            bad;
         logic          exp_rdy;
         stalls = 0; bad = 0;
         start = 1'b1; tick(); start = 1'b0;
         m = 16'hACE1;
         prev = bayer_data;
         for (int i = 0; i < 1000; i++) begin
            bayer_addr = (i % 2 == 0) ? 14'd129 : 14'd385;
            tick();
            m = lfsr_step(m);
            exp_rdy = (m[1:0] != 2'b00);
            if (bayer_ready !== exp_rdy) bad++;
            if (!exp_rdy) begin
               stalls++;
               if (bayer_data !== prev) bad++;
            end
            prev = bayer_data;
         end
         check("stall_pattern", 32'(bad), 32'd0);
         check("stall_cnt", dut.r_stall_cnt, 32'(stalls));
      end
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/bayer_frame_server.md
Name: bayer_frame_server

Overview:
- Memory-side responder for the demosaic engine.
- Holds one Bayer frame of IMG_W x IMG_H 8-bit pixels and serves the engine's bayer_req/bayer_ready/bayer_addr read traffic.
- Captures the engine's acpi_valid/acpi_addr/acpi_data write stream into a result frame and reports frame completion.
- Used as the frame store in integration and as the standard harness endpoint for demosaic regression.

Parameters:
- DATA_WIDTH, 8, pixel width.
- ADDR_WIDTH, 14, frame address width; depth = 2**ADDR_WIDTH.
- IMG_W, 128, row length in pixels (power of 2); row = addr / IMG_W, col = addr % IMG_W.
- IMG_H, 128, row count.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- load_valid  in  1  host preload strobe, input frame.
- load_addr  in  ADDR_WIDTH  preload address.
- load_data  in  DATA_WIDTH  preload pixel.
- start  in  1  one-cycle pulse; begins serving.
- bayer_ready  out  1  server accepts/serves reads this cycle.
- bayer_req  in  1  engine read request.
- bayer_addr  in  ADDR_WIDTH  engine read address.
- bayer_data  out  DATA_WIDTH  read data.
- acpi_valid  in  1  engine result write strobe.
- acpi_addr  in  ADDR_WIDTH  result address.
- acpi_data  in  DATA_WIDTH  result pixel.
- finish  in  1  engine end-of-frame indication.
- rd_addr  in  ADDR_WIDTH  host readback address, result frame.
- rd_data  out  DATA_WIDTH  host readback data.
- wr_count  out  ADDR_WIDTH+1  accepted result writes.
- busy  out  1  high in SERVE and DRAIN.
- done  out  1  frame complete; sticky until start or rst.
- addr_err  out  1  sticky; write to border column (col 0 or IMG_W-1) or row >= IMG_H.

Behaviour:
- Reset values: bayer_ready=0, bayer_data=0, rd_data=0, wr_count=0, busy=0, done=0, addr_err=0, state=IDLE.
- Frame contents are not cleared by rst.
- States:
  - IDLE: load_valid writes in_mem[load_addr] <= load_data; start -> SERVE, clears wr_count/done/addr_err.
  - SERVE: bayer_ready=1 (registered, asserted the cycle after entry).
  - DRAIN: bayer_ready=0, writes still accepted, fixed 4 cycles, then -> DONE.
  - DONE: done=1; start -> SERVE (restart); load_valid permitted.
- load_valid is ignored outside IDLE/DONE.
- Read: in SERVE, bayer_data <= in_mem[bayer_addr] every cycle, independent of bayer_req, so data for the address presented in cycle N is valid in cycle N+1. bayer_req is informational; a read count is kept internally for the optional feature only.
- Write: any state except IDLE, acpi_valid=1 gives out_mem[acpi_addr] <= acpi_data and wr_count+1 (saturates at 2**ADDR_WIDTH).
- A border or out-of-range write is still stored and still counted, and sets addr_err.
- Repeated writes to the same address overwrite; count still increments.
- SERVE -> DRAIN on finish=1, or on wr_count reaching (IMG_W-2)*IMG_H in the same cycle as a write.
- rd_data <= out_mem[rd_addr], 1-cycle latency, all states.
- Simultaneous events:
  - start and finish in the same cycle in DONE: start wins.
  - finish in IDLE: ignored.
  - rst mid-SERVE: outputs return to reset values next edge; writes in that cycle are dropped.
- Address arithmetic is unsigned ADDR_WIDTH; no wrap checking on read addresses.

Optional Feature:
- Macro: BAYER_STALL_EN.
- Defined: a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1, reloaded on rst and start) advances each SERVE cycle. bayer_ready is forced low in cycles where LFSR[1:0]==2'b00. bayer_data holds its previous value during stall cycles. Stall cycles are counted in a stall_cnt register visible to the bench hierarchically.
- Not defined: no LFSR; bayer_ready stays constant high in SERVE.

Test Plan:
- Reset/idle: rst 2 cycles -> bayer_ready=0, busy=0, done=0, wr_count=0; start without preload -> busy=1 next cycle, bayer_ready=1 the cycle after.
- Read latency: preload in_mem[129]=8'h5A, in_mem[385]=8'h3C; SERVE with bayer_addr=129 then 385 -> bayer_data 8'h5A, 8'h3C on the following cycles.
- Full frame: drive the engine with a 128x128 ramp image -> wr_count=16128, then DRAIN 4 cycles, done=1, busy=0; rd_addr=1 returns the engine output.
- Border error: acpi_valid with acpi_addr=128 (col 0) -> addr_err=1 sticky, wr_count+1, out_mem[128] written; restart via start clears addr_err.
- Early finish: finish pulse after 10 writes -> DRAIN, then done=1 with wr_count=10; further writes during DRAIN increment the count.
- BAYER_STALL_EN: 1000 SERVE cycles -> bayer_ready low on exactly the cycles where LFSR[1:0]==0, matching a reference-model count; bayer_data stable during stalls.
